dispense_mode_controller: RTL

- Sequences the 7-bit dispenser command path between normal (controller) mode and maintenance mode.
- Owns the 1-bit select line and the 7-bit command word feeding the output multiplexer.
- Accepts commands from the mbed over a valid/ready handshake.
- Switches modes safely: debounces the maintenance key, drains any in-flight dispense, and forces idle codes during a guard interval.

---
 rtl/chip_mode_pkg.sv | 18 +
 rtl/key_debounce.sv | 52 +++++
 rtl/dispense_mode_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/chip_mode_pkg.sv
// Shared types and constants for the dispenser mode controller.
// Holds the state encoding and the idle command words.
package chip_mode_pkg;

  localparam int CMD_W = 7;

  localparam logic [CMD_W-1:0] CTRL_IDLE  = 7'b1101110;
  localparam logic [CMD_W-1:0] MAINT_IDLE = 7'b0111111;

  typedef enum logic [2:0] {
    NORMAL   = 3'd0,
    DRAIN    = 3'd1,
    SWAP_N2M = 3'd2,
    MAINT    = 3'd3,
    SWAP_M2N = 3'd4
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Maintenance keyswitch synchroniser and debouncer.
// Level flips after DEBOUNCE_LEN consecutive opposite samples.
module key_debounce #(
  parameter int DEBOUNCE_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic maint_db
);

  localparam int CW = $clog2(DEBOUNCE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count run of samples disagreeing with the level; flip on full run.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Two-flop synchroniser plus debounce state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign maint_db = db_q;

endmodule

// File: rtl/dispense_mode_controller.sv
// Switches the dispenser command mux between controller and maintenance.
// MAINT_TIMEOUT_EN adds an idle auto-return from maintenance mode.
module dispense_mode_controller
  import chip_mode_pkg::*;
#(
  parameter int DEBOUNCE_LEN  = 16,
  parameter int GUARD_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 1024
`ifdef MAINT_TIMEOUT_EN
  , parameter int MAINT_IDLE_LIMIT = 65535
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             maint_req,
  input  logic             dispense_busy,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             select,
  output logic [CMD_W-1:0] mux_data,
  output logic             mode_maint,
  output logic             switching,
  output logic             drain_fault
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  localparam int BW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_MAX  = BW'(DRAIN_TIMEOUT);
  localparam logic [BW-1:0] BUSY_LAST = BW'(DRAIN_TIMEOUT - 1);

  logic             maint_db;
  logic             cmd_acc;
  logic             entry_ok;

  state_e           state_q,    state_d;
  logic             sel_q,      sel_d;
  logic [CMD_W-1:0] mux_q,      mux_d;
  logic [GW-1:0]    guard_q,    guard_d;
  logic [BW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             fault_q,    fault_d;

`ifdef MAINT_TIMEOUT_EN
  localparam int TW = $clog2(MAINT_IDLE_LIMIT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MAINT_IDLE_LIMIT - 1);

  logic [TW-1:0]    tmo_q,      tmo_d;
  logic             blk_q,      blk_d;

  assign entry_ok = ~blk_q;
`else
  assign entry_ok = 1'b1;
`endif

  key_debounce #(
    .DEBOUNCE_LEN (DEBOUNCE_LEN)
  ) u_key_debounce (
    .clk      (clk),
    .reset    (reset),
    .key_raw  (maint_req),
    .maint_db (maint_db)
  );

  assign cmd_ready = ((state_q == NORMAL) && !maint_db) ||
                     ((state_q == MAINT)  &&  maint_db);
  assign cmd_acc   = cmd_valid && cmd_ready;

  // Next-state and next-output computation for the mode sequencer.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mux_d      = mux_q;
    guard_d    = guard_q;
    busy_cnt_d = busy_cnt_q;
    fault_d    = fault_q;
`ifdef MAINT_TIMEOUT_EN
    tmo_d      = tmo_q;
    blk_d      = blk_q & maint_db;
`endif
    case (state_q)
      NORMAL: begin
        if (maint_db && entry_ok) begin
          state_d    = DRAIN;
          mux_d      = CTRL_IDLE;
          guard_d    = '0;
          busy_cnt_d = '0;
        end else if (cmd_acc) begin
          mux_d = cmd_data;
        end
      end
      DRAIN: begin
        if (dispense_busy && (busy_cnt_q != BUSY_MAX)) begin
          busy_cnt_d = busy_cnt_q + BW'(1);
          if (busy_cnt_q == BUSY_LAST) begin
            fault_d = 1'b1;
          end
        end
        if (guard_q != GUARD_MAX) begin
          guard_d = guard_q + GW'(1);
        end
        if (!maint_db) begin
          state_d = NORMAL;
          mux_d   = CTRL_IDLE;
        end else if ((guard_q == GUARD_MAX) && !dispense_busy) begin
          state_d = SWAP_N2M;
          sel_d   = 1'b1;
          mux_d   = MAINT_IDLE;
          guard_d = '0;
        end
      end
      SWAP_N2M: begin
        if (guard_q == GUARD_LAST) begin
          state_d = MAINT;
`ifdef MAINT_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      MAINT: begin
        if (!maint_db) begin
          state_d = SWAP_M2N;
          mux_d   = MAINT_IDLE;
          guard_d = '0;
`ifdef MAINT_TIMEOUT_EN
        end else if (cmd_acc) begin
          mux_d = cmd_data;
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = SWAP_M2N;
          mux_d   = MAINT_IDLE;
          guard_d = '0;
          blk_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`else
        end else if (cmd_acc) begin
          mux_d = cmd_data;
        end
`endif
      end
      SWAP_M2N: begin
        if (guard_q == GUARD_LAST) begin
          state_d = NORMAL;
          sel_d   = 1'b0;
          mux_d   = CTRL_IDLE;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: begin
        state_d    = NORMAL;
        sel_d      = 1'b0;
        mux_d      = CTRL_IDLE;
        guard_d    = '0;
        busy_cnt_d = '0;
      end
    endcase
  end

  // Register sequencer state and all mux-facing outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      sel_q      <= 1'b0;
      mux_q      <= CTRL_IDLE;
      guard_q    <= '0;
      busy_cnt_q <= '0;
      fault_q    <= 1'b0;
`ifdef MAINT_TIMEOUT_EN
      tmo_q      <= '0;
      blk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mux_q      <= mux_d;
      guard_q    <= guard_d;
      busy_cnt_q <= busy_cnt_d;
      fault_q    <= fault_d;
`ifdef MAINT_TIMEOUT_EN
      tmo_q      <= tmo_d;
      blk_q      <= blk_d;
`endif
    end
  end

  assign select      = sel_q;
  assign mux_data    = mux_q;
  assign mode_maint  = (state_q == MAINT);
  assign switching   = (state_q == DRAIN) ||
                       (state_q == SWAP_N2M) ||
                       (state_q == SWAP_M2N);
  assign drain_fault = fault_q;

endmodule
